// File: rtl/delay_pkg.sv
// ============================================================================
// Module   : delay_pkg
// Brief    : Shared width helpers and parameter-legality constants for the
//            delay_credit_buffer block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package delay_pkg;

  localparam int c_min_depth   = 2;
  localparam int c_min_latency = 1;

  // Occupancy and credit counters must represent 0..depth inclusive.
  function automatic int cnt_width(input int d);
    return $clog2(d + 1);
  endfunction

  function automatic int ptr_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic bit is_pow2(input int d);
    return (d > 0) && ((d & (d - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/delay_credit_fifo_mem.sv
// ============================================================================
// Module   : delay_credit_fifo_mem
// Brief    : depth x num_bits register storage, one write port and one
//            registered read port with write-through to the read register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module delay_credit_fifo_mem
  import delay_pkg::*;
#(
  parameter int num_bits = 8,
  parameter int depth    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ptr_width(depth)-1:0]  wr_addr,
  input  logic [num_bits-1:0]          wr_data,
  input  logic                         rd_en,
  input  logic [ptr_width(depth)-1:0]  rd_addr,
  output logic [num_bits-1:0]          rd_data
);

  logic [num_bits-1:0] r_mem [depth];
  logic [num_bits-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Forward the write when it targets the entry becoming the head, so a word
  // pushed into an empty FIFO is visible one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/delay_credit_buffer.sv
// ============================================================================
// Module   : delay_credit_buffer
// Brief    : Credit-managed elastic FIFO behind a non-stallable delay line.
//            Optional macro DELAY_CREDIT_BUFFER_BYPASS_EN enables an
//            empty-FIFO combinational bypass from in_data to out_data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module delay_credit_buffer
  import delay_pkg::*;
#(
  parameter int num_bits = 8,
  parameter int latency  = 4,
  parameter int depth    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic                         in_valid,
  input  logic [num_bits-1:0]          in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [num_bits-1:0]          out_data,
  output logic [cnt_width(depth)-1:0]  count,
  output logic                         err_overflow
);

  localparam int  c_cw       = cnt_width(depth);
  localparam int  c_aw       = ptr_width(depth);
  localparam bit  c_cfg_ok   = is_pow2(depth) && (depth >= c_min_depth) &&
                               (latency >= c_min_latency);
  localparam logic [c_cw-1:0] c_depth_cnt = c_cw'(depth);

  generate
    if (!c_cfg_ok) begin : g_param_check
      $error("delay_credit_buffer: depth must be a power of two >= 2 and latency >= 1");
    end
  endgenerate

  logic [c_cw-1:0] r_credits;
  logic            r_issue_ready;
  logic [c_cw-1:0] r_count;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic            r_err;

  logic            w_issue_fire;
  logic            w_bypass;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_pop_fifo;
  logic            w_push;
  logic            w_overflow;
  logic [c_cw-1:0] w_credits_next;
  logic [c_cw-1:0] w_count_next;
  logic [c_aw-1:0] w_rd_ptr_next;
  logic [num_bits-1:0] w_rd_data;

  assign w_issue_fire = issue_valid & r_issue_ready;
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == c_depth_cnt);

`ifdef DELAY_CREDIT_BUFFER_BYPASS_EN
  assign w_bypass = in_valid & w_empty & out_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign out_valid  = ~w_empty | w_bypass;
  assign w_pop      = out_valid & out_ready;
  assign w_pop_fifo = w_pop & ~w_bypass;
  // A full FIFO still accepts an arrival when the head leaves the same cycle.
  assign w_push     = in_valid & ~w_bypass & ~(w_full & ~w_pop_fifo);
  assign w_overflow = in_valid & w_full & ~w_pop_fifo;

  // Bypassed words return their credit too, since they never occupy a slot.
  assign w_credits_next = r_credits
                        - {{(c_cw-1){1'b0}}, w_issue_fire}
                        + {{(c_cw-1){1'b0}}, w_pop};

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop_fifo})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  assign w_rd_ptr_next = r_rd_ptr + {{(c_aw-1){1'b0}}, w_pop_fifo};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_credits     <= c_depth_cnt;
      r_issue_ready <= 1'b1;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_err         <= 1'b0;
    end else begin
      r_credits     <= w_credits_next;
      r_issue_ready <= (w_credits_next != '0);
      r_count       <= w_count_next;
      r_rd_ptr      <= w_rd_ptr_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_overflow) begin
        r_err <= 1'b1;
      end
    end
  end

  delay_credit_fifo_mem #(
    .num_bits (num_bits),
    .depth    (depth)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr),
    .wr_data (in_data),
    .rd_en   (w_push | w_pop_fifo),
    .rd_addr (w_rd_ptr_next),
    .rd_data (w_rd_data)
  );

  assign issue_ready  = r_issue_ready;
  assign count        = r_count;
  assign err_overflow = r_err;
  assign out_data     = w_bypass ? in_data : w_rd_data;

endmodule

`default_nettype wire
